scl_clk_gen_filter: RTL and testbench
=====================================

SCL_CLK_GEN_FILTER -- requirements
Module: scl_clk_gen_filter

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 Parameter SCL_FREQ_HZ, default 100_000, generated SCL frequency (I2C standard mode).
REQ-003 Parameter STAGES, default 2, number of agreeing samples the glitch filter requires.
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 en  input  1  SCL generator run enable; 1 = toggle, 0 = hold released.
REQ-007 scl_i  output  1  generated SCL drive value to the SCL IOBUF I input.
REQ-008 scl_o  input  1  raw SCL pad readback from the IOBUF O output; asynchronous.
REQ-009 scl_filt  output  1  synchronized, glitch-filtered SCL.
REQ-010 scl_rise  output  1  one-cycle pulse on a scl_filt 0->1 change.
REQ-011 scl_fall  output  1  one-cycle pulse on a scl_filt 1->0 change.

Function
REQ-012 HALF = CLK_FREQ_HZ / (2*SCL_FREQ_HZ), integer division; the default is 500.
REQ-013 Elaboration SHALL fail if HALF < 2 or STAGES < 1.
REQ-014 The generator SHALL use a half-period counter of width clog2(HALF), counting 0..HALF-1.
REQ-015 While en=1, the counter increments each cycle; at HALF-1 it wraps to 0 and scl_i inverts in the same cycle.
REQ-016 Resulting SCL period SHALL be exactly 2*HALF cycles with 50% duty; the default is 1000 cycles, i.e. 10 us.
REQ-017 While en=0, the counter SHALL be held at 0 and scl_i held at 1, so the bus is released.
REQ-018 On en 0->1, the first scl_i fall SHALL occur HALF cycles after the first cycle with en=1, leaving a full high half-period for START setup.
REQ-019 When en drops mid-period, scl_i SHALL return to 1 on the next clock edge and the count SHALL be discarded.
REQ-020 The filter input SHALL pass through a 2-flop synchronizer (sync1, sync2) before any use.
REQ-021 A STAGES-deep shift register SHALL sample sync2 every cycle.
REQ-022 When all STAGES samples are equal, scl_filt SHALL take that value on the next edge; otherwise scl_filt holds.
REQ-023 A stable input change SHALL appear on scl_filt exactly 2+STAGES cycles later; this is 4 cycles, or 40 ns, at defaults.
REQ-024 Pulses shorter than STAGES cycles SHALL never change scl_filt.
REQ-025 scl_rise and scl_fall SHALL be registered compares of scl_filt with its previous value.
REQ-026 scl_rise and scl_fall are high for exactly the one cycle after scl_filt changes, and are never both high.
REQ-027 The generator and the filter SHALL be independent; scl_o is never internally looped from scl_i.

Reset
REQ-028 While rst=1: counter=0, scl_i=1, sync1=sync2=1, all filter samples=1, scl_filt=1, previous-value reg=1, scl_rise=scl_fall=0.
REQ-029 rst SHALL override en; reset mid-period restarts timing per REQ-018 once rst=0 and en=1.
REQ-030 The first cycle after reset SHALL produce no rise/fall pulse, even if scl_o=0; scl_fall asserts only after the filter latency.

Verification
REQ-031 Defaults, rst then en=1 -> scl_i=1 for 500 cycles, falls at cycle 500, rises at cycle 1000, period 1000 across 10 consecutive periods.
REQ-032 en=1, scl_o looped to scl_i externally -> scl_filt mirrors scl_i delayed 4 cycles; exactly one scl_fall and one scl_rise per period.
REQ-033 scl_o steady 1, then 1-cycle 0 glitch -> scl_filt stays 1, no pulses.
REQ-034 Same with a 2-cycle 0 -> scl_filt=0 for 2 cycles, starting 4 cycles after the glitch starts; single scl_fall, then single scl_rise.
REQ-035 en=1 for 300 cycles, then en=0 for 10, then en=1 -> scl_i stays 1 throughout; the next fall occurs 500 cycles after en returns to 1.
REQ-036 rst asserted at cycle 750 of a run, with scl_i low -> next cycle scl_i=1, scl_filt=1, counter=0; after release, the first fall comes 500 cycles later.
REQ-037 Parameter sweep CLK_FREQ_HZ=10_000_000, STAGES=3 -> SCL period 100 cycles; filter latency 5 cycles; 2-cycle glitch rejected.

Source files
------------

// File: rtl/scl_clk_gen_filter_if.sv
// SCL generator / filter signal bundle: generated drive value, pad readback,
// and the filtered SCL with its edge pulses.
interface scl_clk_gen_filter_if;
  logic en;
  logic scl_i;
  logic scl_o;
  logic scl_filt;
  logic scl_rise;
  logic scl_fall;

  modport master (
    output en, scl_o,
    input  scl_i, scl_filt, scl_rise, scl_fall
  );

  modport slave (
    input  en, scl_o,
    output scl_i, scl_filt, scl_rise, scl_fall
  );
endinterface

// File: rtl/scl_clk_gen_filter.sv
// 50% duty SCL generator plus an independent synchronizer / glitch filter
// for the SCL pad readback, with registered rise/fall pulses.
module scl_clk_gen_filter #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned SCL_FREQ_HZ = 100_000,
  parameter int unsigned STAGES      = 2
) (
  input  logic                 CLK,
  input  logic                 rst,
  scl_clk_gen_filter_if.slave  bus
);

  localparam int unsigned HALF = CLK_FREQ_HZ / (2 * SCL_FREQ_HZ);
  localparam int unsigned CW   = (HALF < 2) ? 1 : $clog2(HALF);

  if (HALF < 2 || STAGES < 1) begin : g_param_check
    $error("scl_clk_gen_filter: HALF must be >= 2 and STAGES >= 1");
  end

  // Half-period generator; en low keeps the bus released and the count cleared.
  logic [CW-1:0] cnt;
  logic          scl_q;

  always_ff @(posedge CLK) begin
    if (rst || !bus.en) begin
      cnt   <= '0;
      scl_q <= 1'b1;
    end else if (cnt == CW'(HALF - 1)) begin
      cnt   <= '0;
      scl_q <= ~scl_q;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  assign bus.scl_i = scl_q;

  // Agreement window: sync2 plus the STAGES-1 samples before it, so a stable
  // change reaches scl_filt 2+STAGES cycles after it appears on the pad.
  logic              sync1;
  logic              sync2;
  logic [STAGES-1:0] win;

  if (STAGES == 1) begin : g_win_single
    assign win = sync2;
  end else begin : g_win_shift
    localparam int unsigned HW = STAGES - 1;
    logic [HW-1:0] hist;

    always_ff @(posedge CLK) begin
      if (rst) hist <= '1;
      else     hist <= HW'({hist, sync2});
    end

    assign win = {hist, sync2};
  end

  logic filt_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync1 <= bus.scl_o;
      sync2 <= sync1;
      if (&win)       filt_q <= 1'b1;
      else if (~|win) filt_q <= 1'b0;
      prev_q <= filt_q;
      rise_q <= filt_q & ~prev_q;
      fall_q <= ~filt_q & prev_q;
    end
  end

  assign bus.scl_filt = filt_q;
  assign bus.scl_rise = rise_q;
  assign bus.scl_fall = fall_q;

endmodule

// File: tb/tb_scl_clk_gen_filter.sv
// Scoreboard bench: default instance and a 10 MHz / STAGES=3 instance driven
// side by side, each checked cycle by cycle against an arithmetic model.
module tb_scl_clk_gen_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   loop_a = 1'b0;
  bit   loop_b = 1'b0;

  always #5 clk = ~clk;

  scl_clk_gen_filter_if ifa ();
  scl_clk_gen_filter_if ifb ();

  scl_clk_gen_filter dut_a (
    .CLK (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  scl_clk_gen_filter #(
    .CLK_FREQ_HZ (10_000_000),
    .SCL_FREQ_HZ (100_000),
    .STAGES      (3)
  ) dut_b (
    .CLK (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef struct {
    int          m;     // consecutive en=1 cycles since last release
    bit          scl;
    bit [31:0]   hist;  // pad samples, bit 0 = newest
    bit          f;
    bit          p;
    bit          r;
    bit          fl;
  } mstate_t;

  // SCL is high in the even HALF-long slices of the en run; filt follows the
  // pad value once the STAGES samples two cycles back all agree.
  function automatic mstate_t step(input mstate_t s, input bit r_in, input bit en_in,
                                   input bit so, input int half, input int stages);
    mstate_t   n;
    bit [31:0] mask;
    bit [31:0] w;
    n = s;
    if (r_in) begin
      n.m = 0; n.scl = 1'b1; n.hist = '1;
      n.f = 1'b1; n.p = 1'b1; n.r = 1'b0; n.fl = 1'b0;
      return n;
    end
    if (!en_in) begin
      n.m = 0; n.scl = 1'b1;
    end else begin
      n.m   = s.m + 1;
      n.scl = ((n.m / half) % 2) == 0;
    end
    n.hist = {s.hist[30:0], so};
    mask   = ((32'd1 << stages) - 32'd1) << 2;
    w      = n.hist & mask;
    if (w == mask)    n.f = 1'b1;
    else if (w == 0)  n.f = 1'b0;
    n.r  = s.f & ~s.p;
    n.fl = ~s.f & s.p;
    n.p  = s.f;
    return n;
  endfunction

  mstate_t  sa, sb;
  bit [3:0] qa[$];
  bit [3:0] qb[$];
  int       n_cmp = 0;
  int       n_err = 0;
  int       cyc_no = 0;

  // Stimulus side: predict post-edge outputs and queue them.
  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    sa = step(sa, rst, ifa.en, ifa.scl_o, 500, 2);
    sb = step(sb, rst, ifb.en, ifb.scl_o, 50, 3);
    qa.push_back({sa.scl, sa.f, sa.r, sa.fl});
    qb.push_back({sb.scl, sb.f, sb.r, sb.fl});
  end

  // Monitor side: pop and compare against what each DUT presents.
  always @(negedge clk) begin
    bit [3:0] exp_v;
    bit [3:0] act_v;
    if (qa.size() > 0) begin
      exp_v = qa.pop_front();
      act_v = {ifa.scl_i, ifa.scl_filt, ifa.scl_rise, ifa.scl_fall};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL dut_a cycle %0d {scl_i,filt,rise,fall}: got %b expected %b",
                 cyc_no, act_v, exp_v);
      end
    end
    if (qb.size() > 0) begin
      exp_v = qb.pop_front();
      act_v = {ifb.scl_i, ifb.scl_filt, ifb.scl_rise, ifb.scl_fall};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL dut_b cycle %0d {scl_i,filt,rise,fall}: got %b expected %b",
                 cyc_no, act_v, exp_v);
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (loop_a) ifa.scl_o = ifa.scl_i;
      if (loop_b) ifb.scl_o = ifb.scl_i;
    end
  endtask

  task automatic set_pad(input bit v);
    ifa.scl_o = v;
    ifb.scl_o = v;
  endtask

  task automatic set_en(input bit v);
    ifa.en = v;
    ifb.en = v;
  endtask

  initial begin
    set_en(1'b0);
    set_pad(1'b1);
    cyc(3);
    // Pad low straight out of reset: no pulse until the filter latency passes.
    rst = 1'b0;
    set_pad(1'b0);
    cyc(10);
    set_pad(1'b1);
    cyc(10);

    // Free-running SCL, pad looped back externally, 10+ default periods.
    set_en(1'b1);
    loop_a = 1'b1;
    loop_b = 1'b1;
    cyc(10_500);
    loop_a = 1'b0;
    loop_b = 1'b0;
    set_en(1'b0);
    set_pad(1'b1);
    cyc(12);

    // Directed low glitches of 1, 2, 3 cycles, then random widths and gaps.
    for (int wdt = 1; wdt <= 3; wdt++) begin
      set_pad(1'b0);
      cyc(wdt);
      set_pad(1'b1);
      cyc(12);
    end
    for (int i = 0; i < 200; i++) begin
      set_pad(1'b0);
      cyc($urandom_range(1, 4));
      set_pad(1'b1);
      cyc($urandom_range(3, 12));
    end
    cyc(10);

    // en dropped mid-period, then resumed.
    set_en(1'b1);
    cyc(300);
    set_en(1'b0);
    cyc(10);
    set_en(1'b1);
    cyc(600);

    // Reset while SCL is low (cycle 750 of a run), then restart.
    set_en(1'b0);
    cyc(2);
    set_en(1'b1);
    cyc(750);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1_100);

    // Random en / rst / pad activity, with occasional loopback.
    for (int i = 0; i < 3_000; i++) begin
      if ($urandom_range(0, 299) == 0) set_en(~ifa.en);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 499) == 0) begin
        loop_a = ~loop_a;
        loop_b = loop_a;
      end
      if (!loop_a && $urandom_range(0, 9) == 0) set_pad(~ifa.scl_o);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
